// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared definitions for the instruction fetch block: FSM state
//            encoding, program-counter step, queue entry layout and a
//            small address-alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch request tracking state.
  //   ST_IDLE    : nothing outstanding at the instruction memory
  //   ST_WAIT    : request outstanding, its data will be queued
  //   ST_DISCARD : request outstanding, its data will be thrown away
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP = 32'd4;

  // One instruction queue entry: {pc, inst} as a 64-bit word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Bundles the instruction-memory request channel, the redirect
//            input and the decode-side instruction channel of the fetch unit.
//   master : fetch unit view (drives imem_req/imem_addr and inst_*)
//   slave  : environment view (memory, branch unit and decode stage)
// Signals  : imem_req, imem_addr[31:0], imem_ack, imem_data[31:0],
//            redirect, redirect_pc[31:0], inst_valid, inst[31:0],
//            inst_pc[31:0], inst_ready
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data,
    input  redirect,
    input  redirect_pc,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data,
    output redirect,
    output redirect_pc,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Synchronous FIFO of fetched {pc, inst} entries. Head entry is
//            presented combinationally from storage, so a push is visible
//            the cycle after its clock edge. Flush empties the queue.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_push/i_data - write one entry
//            i_pop         - retire the head entry (ignored when empty)
//            i_flush       - discard all entries (wins over push/pop)
//            o_head        - current head entry
//            o_count       - number of stored entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_entry_t             i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full = (c_aw + 1)'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full queue can still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && ((r_count != c_full) || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Issues one word-aligned request
//            at a time to instruction memory, queues returned words with
//            their addresses and hands them to decode. A redirect flushes
//            the queue and restarts fetching at the new address; data from
//            a request already in flight at that moment is dropped.
// Ports    : clk          - rising-edge clock
//            rst          - synchronous active-high reset
//            bus (master) - imem_req/imem_addr/imem_ack/imem_data,
//                           redirect/redirect_pc,
//                           inst_valid/inst/inst_pc/inst_ready
// Params   : QDEPTH   - queue depth, power of two in 2..16
//            RESET_PC - fetch address after reset
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int c_cw = $clog2(QDEPTH) + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(QDEPTH);

  fetch_state_e    r_state;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_req_addr;

  logic [c_cw-1:0] w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_issue;
  logic            w_req;
  logic            w_ack;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [31:0]     w_addr;

  // A new request may leave IDLE only with a free queue slot; that slot is
  // effectively reserved because nothing else can push until it returns.
  assign w_issue = !rst && (r_state == ST_IDLE) && (w_count < c_full) && !bus.redirect;
  assign w_req   = !rst && (w_issue || (r_state != ST_IDLE));

  // While a request is outstanding its address is held in r_req_addr, since
  // a redirect during WAIT/DISCARD moves r_fetch_pc but must not move the bus.
  assign w_addr  = (r_state == ST_IDLE) ? r_fetch_pc : r_req_addr;

  // An ack on the cycle of issue completes the request immediately.
  assign w_ack   = w_req && bus.imem_ack;
  assign w_push  = w_ack && !bus.redirect && (r_state != ST_DISCARD);

  assign w_valid = !rst && (w_count != '0);
  assign w_pop   = w_valid && bus.inst_ready && !bus.redirect;

  assign w_push_data.pc   = w_addr;
  assign w_push_data.inst = bus.imem_data;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (bus.redirect) begin
        r_fetch_pc <= align_pc(bus.redirect_pc);
      end else if (w_push) begin
        r_fetch_pc <= w_addr + PC_STEP;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_req_addr <= r_fetch_pc;
            if (!bus.imem_ack) r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack)      r_state <= ST_IDLE;
          else if (bus.redirect) r_state <= ST_DISCARD;
        end
        ST_DISCARD: begin
          if (bus.imem_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = w_addr;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A reference model built
//            from a plain queue of {pc, inst} words and an "outstanding
//            request" record predicts the outputs every cycle; directed
//            scenarios add literal expectations, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          QD  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_if bus ();

  fetch_unit #(
    .QDEPTH   (QD),
    .RESET_PC (RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mq[$];
  logic [31:0] m_pc       = RPC;
  bit          m_out      = 1'b0;
  logic [31:0] m_out_addr = 32'h0;
  bit          m_drop     = 1'b0;
  bit          e_req;
  bit          e_valid;
  logic [31:0] e_addr;

  // Checks outputs mid-cycle, then advances the model across the coming edge
  // (inputs do not change again before that edge).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      e_req   = !rst && (m_out || ((mq.size() < QD) && !bus.redirect));
      e_addr  = m_out ? m_out_addr : m_pc;
      e_valid = !rst && (mq.size() != 0);
      chk("imem_req", 32'(bus.imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
      chk("inst_valid", 32'(bus.inst_valid), 32'(e_valid));
      if (e_valid) begin
        chk("inst_pc", bus.inst_pc, mq[0][63:32]);
        chk("inst", bus.inst, mq[0][31:0]);
      end
      if (rst) begin
        mq.delete();
        m_pc   = RPC;
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else begin
        if (e_valid && bus.inst_ready && !bus.redirect) void'(mq.pop_front());
        if (bus.redirect) mq.delete();
        if (e_req && bus.imem_ack) begin
          if (!m_drop && !bus.redirect) begin
            mq.push_back({e_addr, bus.imem_data});
            m_pc = e_addr + 32'd4;
          end
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else if (e_req) begin
          if (!m_out) begin
            m_out      = 1'b1;
            m_out_addr = e_addr;
            m_drop     = 1'b0;
          end
          if (bus.redirect) m_drop = 1'b1;
        end
        if (bus.redirect) m_pc = {bus.redirect_pc[31:2], 2'b00};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit ack, input bit rdy, input bit redir,
                     input logic [31:0] rpc);
    @(negedge clk);
    rst             = r;
    bus.imem_ack    = ack;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    bus.imem_data   = $urandom;
    #3;
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_data   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;

    // Reset state, then streaming with ack every cycle.
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("s1_req0", 32'(bus.imem_req), 32'd1);
    chk("s1_addr0", bus.imem_addr, 32'h0);
    chk("s1_valid0", 32'(bus.inst_valid), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("s1_addr1", bus.imem_addr, 32'h4);
    chk("s1_valid1", 32'(bus.inst_valid), 32'd1);
    chk("s1_pc1", bus.inst_pc, 32'h0);
    cyc(0, 1, 1, 0, 0);
    chk("s1_addr2", bus.imem_addr, 32'h8);
    chk("s1_pc2", bus.inst_pc, 32'h4);

    // Fill to full with decode stalled, then release one slot.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk("s2_req", 32'(bus.imem_req), 32'd1);
      chk("s2_addr", bus.imem_addr, 32'(i * 4));
    end
    cyc(0, 1, 0, 0, 0);
    chk("s2_full_req", 32'(bus.imem_req), 32'd0);
    chk("s2_full_valid", 32'(bus.inst_valid), 32'd1);
    chk("s2_head_pc", bus.inst_pc, 32'h0);
    chk("s2_model_count", 32'(mq.size()), 32'd4);
    cyc(0, 1, 1, 0, 0);
    chk("s2_pop_req", 32'(bus.imem_req), 32'd0);
    cyc(0, 1, 0, 0, 0);
    chk("s2_next_req", 32'(bus.imem_req), 32'd1);
    chk("s2_next_addr", bus.imem_addr, 32'h10);
    chk("s2_next_head", bus.inst_pc, 32'h4);

    // Ack delayed by three cycles: request held stable.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("s3_hold_req", 32'(bus.imem_req), 32'd1);
      chk("s3_hold_addr", bus.imem_addr, 32'h0);
    end
    cyc(0, 1, 0, 0, 0);
    chk("s3_ack_addr", bus.imem_addr, 32'h0);
    chk("s3_ack_valid", 32'(bus.inst_valid), 32'd0);
    cyc(0, 0, 1, 0, 0);
    chk("s3_valid", 32'(bus.inst_valid), 32'd1);
    chk("s3_pc", bus.inst_pc, 32'h0);
    chk("s3_next_addr", bus.imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 0);
    chk("s3_single", 32'(bus.inst_valid), 32'd0);

    // Redirect while waiting; late ack is dropped.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s4_addr0", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 1, 32'h103);
    chk("s4_redir_req", 32'(bus.imem_req), 32'd1);
    chk("s4_redir_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("s4_disc_addr", bus.imem_addr, 32'h0);
    cyc(0, 1, 0, 0, 0);
    chk("s4_disc_ack_addr", bus.imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0);
    chk("s4_empty", 32'(bus.inst_valid), 32'd0);
    chk("s4_new_req", 32'(bus.imem_req), 32'd1);
    chk("s4_new_addr", bus.imem_addr, 32'h100);

    // Redirect and ack together with two entries queued.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s5_addr", bus.imem_addr, 32'h8);
    cyc(0, 1, 1, 1, 32'h200);
    chk("s5_valid_before", 32'(bus.inst_valid), 32'd1);
    cyc(0, 0, 0, 0, 0);
    chk("s5_flushed", 32'(bus.inst_valid), 32'd0);
    chk("s5_req", 32'(bus.imem_req), 32'd1);
    chk("s5_addr_new", bus.imem_addr, 32'h200);

    // Reset in the middle of a wait, with an ack arriving during reset.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("s6_wait_addr", bus.imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("s6_rst_req", 32'(bus.imem_req), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("s6_restart_req", 32'(bus.imem_req), 32'd1);
    chk("s6_restart_addr", bus.imem_addr, RPC);
    chk("s6_restart_valid", 32'(bus.inst_valid), 32'd0);

    // Random traffic, alternating between mostly-draining and mostly-stalled
    // decode so both empty and full queue conditions recur.
    for (int i = 0; i < 4000; i++) begin
      bit          r_r, r_ack, r_rdy, r_red;
      logic [31:0] r_pc;
      r_r   = ($urandom_range(0, 299) == 0);
      r_ack = ($urandom_range(0, 2) != 0);
      r_rdy = ((i / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 3) == 0);
      r_red = ($urandom_range(0, 15) == 0);
      r_pc  = $urandom;
      cyc(r_r, r_ack, r_rdy, r_red, r_pc);
    end

    cyc(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QDEPTH, default 4, SHALL set the instruction queue depth; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0, SHALL set the fetch address loaded at reset.
REQ-003 Reset: rst, synchronous, active-high; clock: clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  byte address of the request, word aligned.
REQ-008 imem_ack  in  1  memory response valid, sampled only while imem_req=1.
REQ-009 imem_data  in  32  instruction word, valid with imem_ack.
REQ-010 redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  32  new fetch address, valid with redirect.
REQ-012 inst_valid  out  1  queue head holds a valid instruction.
REQ-013 inst  out  32  queue head instruction word.
REQ-014 inst_pc  out  32  address of the queue head instruction.
REQ-015 inst_ready  in  1  decode stage accepts the head this cycle.

Function
REQ-016 FSM states: IDLE (no request outstanding), WAIT (request outstanding, result kept), DISCARD (request outstanding, result dropped).
REQ-017 IDLE->WAIT when count+0 < QDEPTH and redirect=0; imem_req=1 in the same cycle the transition condition holds.
REQ-018 In WAIT/DISCARD, imem_req SHALL stay 1 and imem_addr SHALL stay stable until imem_ack=1.
REQ-019 Only one request SHALL be outstanding at any time.
REQ-020 WAIT with imem_ack=1 and redirect=0: push {fetch_pc, imem_data}; fetch_pc += 4 (mod 2^32); next state IDLE.
REQ-021 Pushed entries SHALL be visible on inst_valid/inst/inst_pc the cycle after the ack edge (1-cycle latency).
REQ-022 A pop SHALL occur when inst_valid=1 and inst_ready=1; a push and a pop in the same cycle leave count unchanged.
REQ-023 inst_valid = (count != 0); inst and inst_pc are don't-care when inst_valid=0.
REQ-024 redirect=1 SHALL flush the queue (count=0 next cycle), load fetch_pc with {redirect_pc[31:2],2'b00}, and ignore any same-cycle pop.
REQ-025 redirect in WAIT without ack -> DISCARD; redirect in WAIT with ack -> data dropped, next state IDLE.
REQ-026 DISCARD with imem_ack=1: data dropped, next state IDLE; redirect in DISCARD only updates fetch_pc.
REQ-027 No request SHALL issue in a cycle where redirect=1; the next fetch uses the new fetch_pc.
REQ-028 Queue read/write pointers SHALL wrap modulo QDEPTH; count ranges 0..QDEPTH.
REQ-029 Full queue (count=QDEPTH) SHALL suppress new requests; an outstanding request always has a free slot because issue requires count < QDEPTH and push reserves it.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0; imem_req=0 and inst_valid=0 while rst=1.
REQ-031 Reset during WAIT/DISCARD SHALL abandon the request; a late imem_ack after reset is ignored while in IDLE.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2) and the constant PC_STEP=4.
REQ-033 The queue SHALL be a separate sub-module fetch_queue (synchronous FIFO, 64-bit entries {pc, inst}, push/pop/flush, count output).

Verification
REQ-034 Reset release, imem_ack=1 every cycle, inst_ready=1 -> imem_addr 0,4,8,... on consecutive requests; inst_pc 0 with inst_valid=1 in cycle 1.
REQ-035 inst_ready=0, ack always 1 -> exactly 4 pushes (pc 0..12), then imem_req=0 with count=4; inst_ready=1 for one cycle -> next request at addr 16.
REQ-036 Ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; a single entry pushed.
REQ-037 redirect with redirect_pc=32'h103 while WAIT, ack two cycles later -> data dropped, queue empty, next imem_addr=32'h100.
REQ-038 redirect and imem_ack in the same WAIT cycle with count=2 -> count=0 next cycle, no push, next request at redirect_pc.
REQ-039 rst asserted mid-WAIT, then late ack -> no push, fetch restarts at RESET_PC.
